// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption sequencer.
// Owns the 128-bit state register and the round counter. It drives one external
// combinational round datapath per cycle and selects the round key index. Blocks
// enter and leave through valid/ready handshakes.
// Optional build macro: AES_ROUND_CTRL_STALL_EN adds an rk_valid input. While
// rk_valid is low, acceptance and round advance are held off.
module aes_round_ctrl #(
    parameter int NR    = 10,   // rounds, 2..14
    parameter int CNT_W = 4     // 2**CNT_W must exceed NR
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef AES_ROUND_CTRL_STALL_EN
    input  logic             rk_valid,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    input  logic             abort,
    output logic [CNT_W-1:0] rk_idx,
    input  logic [127:0]     rk_data,
    output logic [127:0]     dp_state,
    output logic             dp_last,
    input  logic [127:0]     dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NR);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    fsm_t             fsm;
    logic [CNT_W-1:0] round;
    logic [127:0]     state;
    logic             rk_ok;

`ifdef AES_ROUND_CTRL_STALL_EN
    assign rk_ok = rk_valid;
`else
    assign rk_ok = 1'b1;
`endif

    // round is held at 0 outside RUN, so it doubles as the key index everywhere
    assign rk_idx    = round;
    assign dp_state  = state;
    assign out_block = state;

    // Sequencer: abort beats everything except reset; outputs are registered alongside the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            round     <= '0;
            state     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            dp_last   <= 1'b0;
        end else if (abort) begin
            // state register deliberately left as is
            fsm       <= IDLE;
            round     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            dp_last   <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && rk_ok) begin
                        // initial AddRoundKey with round key 0
                        state    <= in_block ^ rk_data;
                        round    <= ONE;
                        fsm      <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        dp_last  <= (ONE == LAST);
                    end
                end
                RUN: begin
                    if (rk_ok) begin
                        state <= dp_result;
                        if (round == LAST) begin
                            fsm       <= DONE;
                            round     <= '0;
                            out_valid <= 1'b1;
                            dp_last   <= 1'b0;
                        end else begin
                            round   <= round + ONE;
                            dp_last <= ((round + ONE) == LAST);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    round     <= '0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    dp_last   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: bench for aes_round_ctrl with behavioural AES-128 key
// schedule and round datapath models, plus a whole-block reference encryptor.
module tb_aes_round_ctrl;

    localparam int NR    = 10;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, abort, out_ready;
    logic [127:0]     in_block, rk_data, dp_result, cur_key;
    logic             in_ready, out_valid, busy, dp_last;
    logic [CNT_W-1:0] rk_idx;
    logic [127:0]     dp_state, out_block;
`ifdef AES_ROUND_CTRL_STALL_EN
    logic             rk_valid;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef AES_ROUND_CTRL_STALL_EN
        .rk_valid  (rk_valid),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .abort     (abort),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .dp_state  (dp_state),
        .dp_last   (dp_last),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    // ---------------- AES-128 behavioural model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (b^254) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r, p, e;
        r = 8'h01;
        p = b;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        if (idx < 0 || idx > 10) return '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   t0, t1, t2, t3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r + 4*((c+r)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                t0 = b[4*c]; t1 = b[4*c+1]; t2 = b[4*c+2]; t3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, t0) ^ gmul(8'h03, t1) ^ t2 ^ t3;
                b[4*c+1] = t0 ^ gmul(8'h02, t1) ^ gmul(8'h03, t2) ^ t3;
                b[4*c+2] = t0 ^ t1 ^ gmul(8'h02, t2) ^ gmul(8'h03, t3);
                b[4*c+3] = gmul(8'h03, t0) ^ t1 ^ t2 ^ gmul(8'h02, t3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        s = pt ^ key;
        for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(key, r), r == 10);
        return s;
    endfunction

    // external key store and round datapath seen by the controller
    assign rk_data   = round_key(cur_key, int'(rk_idx));
    assign dp_result = aes_round(dp_state, rk_data, dp_last);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
        chk({tag, "_dp_last"}, 128'(dp_last), 128'(0));
    endtask

    // one block from offer to handshake-out, with `hold` cycles of out_ready=0 in DONE
    task automatic do_block(input string tag, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct, input int hold);
        int k;
        cur_key  = key;
        in_block = pt;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin step(); k++; end
        chk({tag, "_offer_rdy"}, 128'(in_ready), 128'(1));
        step();
        in_valid = 1'b0;
        in_block = rnd128();
        k = 0;
        while (!out_valid && k < 4*NR) begin
            chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(k+1));
            chk({tag, "_dp_last"}, 128'(dp_last), 128'(k+1 == NR));
            if (k == 0) begin
                chk({tag, "_run_rdy"}, 128'(in_ready), 128'(0));
                chk({tag, "_run_busy"}, 128'(busy), 128'(1));
            end
            step();
            k++;
        end
        chk({tag, "_latency"}, 128'(k), 128'(NR));
        chk({tag, "_ct"}, out_block, ct);
        chk({tag, "_done_idx"}, 128'(rk_idx), 128'(0));
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_hold_ov"}, 128'(out_valid), 128'(1));
            chk({tag, "_hold_ct"}, out_block, ct);
            chk({tag, "_hold_rdy"}, 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_idle({tag, "_after"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int               k, seen, nacc;
        int               acc_t [$];
        logic [127:0]     exp_q [$];
        logic [127:0]     pts [3];
        logic [127:0]     key, pt;

        rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        in_block = '0; cur_key = FIPS_KEY;
`ifdef AES_ROUND_CTRL_STALL_EN
        rk_valid = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset_state", out_block, 128'h0);
        rst_n = 1'b1;
        step();

        // FIPS-197 vector, then backpressure for 5 cycles
        do_block("fips", FIPS_PT, FIPS_KEY, FIPS_CT, 0);
        do_block("bp", FIPS_PT, FIPS_KEY, FIPS_CT, 5);

        // random blocks against the reference encryptor
        for (int i = 0; i < 4; i++) begin
            key = rnd128();
            pt  = rnd128();
            do_block("rand", pt, key, aes_encrypt(pt, key), int'($urandom_range(0, 3)));
        end

        // back-to-back: in_valid held, out_ready held
        key = rnd128();
        cur_key = key;
        for (int i = 0; i < 3; i++) pts[i] = rnd128();
        nacc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_block = pts[0];
        for (int cyc = 0; cyc < 100 && (nacc < 3 || exp_q.size() > 0); cyc++) begin
            if (out_valid) begin
                if (exp_q.size() > 0) chk("b2b_ct", out_block, exp_q.pop_front());
                else chk("b2b_spurious_ov", 128'(out_valid), 128'(0));
            end
            if (in_ready && in_valid) begin
                acc_t.push_back(cyc);
                exp_q.push_back(aes_encrypt(in_block, key));
                nacc++;
            end
            step();
            if (nacc < 3) in_block = pts[nacc];
            else in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("b2b_accepts", 128'(nacc), 128'(3));
        chk("b2b_drained", 128'(exp_q.size()), 128'(0));
        for (int i = 1; i < acc_t.size(); i++)
            chk("b2b_interval", 128'(acc_t[i] - acc_t[i-1]), 128'(NR + 2));
        step();

        // abort at round 4
        cur_key = rnd128();
        in_block = rnd128();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (rk_idx != CNT_W'(4) && k < 20) begin step(); k++; end
        chk("abort_reach_r4", 128'(rk_idx), 128'(4));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort");
        seen = 0;
        repeat (NR + 3) begin
            step();
            if (out_valid) seen++;
        end
        chk("abort_no_ov", 128'(seen), 128'(0));
        // a block offered during abort is refused
        in_valid = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_refuse_busy", 128'(busy), 128'(0));
        chk("abort_refuse_rdy", 128'(in_ready), 128'(1));
        key = rnd128(); pt = rnd128();
        do_block("post_abort", pt, key, aes_encrypt(pt, key), 1);

        // asynchronous reset between edges mid-run
        cur_key = rnd128();
        in_block = rnd128();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("prerst_busy", 128'(busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_state", out_block, 128'h0);
        #2 rst_n = 1'b1;
        step();
        key = rnd128(); pt = rnd128();
        do_block("post_rst", pt, key, aes_encrypt(pt, key), 0);

`ifdef AES_ROUND_CTRL_STALL_EN
        // key schedule stalls for 3 cycles at round 7
        cur_key = FIPS_KEY;
        in_block = FIPS_PT;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        k = 0;
        while (rk_idx != CNT_W'(7) && k < 20) begin step(); k++; end
        chk("stall_reach_r7", 128'(rk_idx), 128'(7));
        rk_valid = 1'b0;
        repeat (3) begin
            step();
            k++;
            chk("stall_idx_held", 128'(rk_idx), 128'(7));
        end
        rk_valid = 1'b1;
        while (!out_valid && k < 40) begin step(); k++; end
        chk("stall_latency", 128'(k), 128'(NR + 3));
        chk("stall_ct", out_block, FIPS_CT);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_idle("stall_after");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench exceeded time bound");
    end

endmodule
